// File: rtl/pipeline_pkg.sv
// Shared encodings for the Decode/Execute slice: opcode classes, immediate
// extension selects, ALU operations and the packed Execute-stage control word.
package pipeline_pkg;

    typedef enum logic [1:0] {
        OP_DP  = 2'b00,
        OP_MEM = 2'b01,
        OP_BR  = 2'b10,
        OP_NOP = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IMM_ZX8  = 2'b00,
        IMM_ZX12 = 2'b01,
        IMM_BR24 = 2'b10,
        IMM_NONE = 2'b11
    } imm_src_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_ORR = 2'b11
    } alu_ctrl_t;

    // Data-processing cmd field values (InstD[24:21])
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    typedef struct packed {
        logic      pc_src;
        logic      reg_write;
        logic      mem_to_reg;
        logic      mem_write;
        logic      branch;
        logic      alu_src;
        alu_ctrl_t alu_control;
        logic [1:0] flag_write;
    } de_ctrl_t;

    localparam de_ctrl_t CTRL_NOP = '{pc_src: 1'b0, reg_write: 1'b0, mem_to_reg: 1'b0,
                                      mem_write: 1'b0, branch: 1'b0, alu_src: 1'b0,
                                      alu_control: ALU_ADD, flag_write: 2'b00};

endpackage

// File: rtl/decode_pipe_reg_file_bypass.sv
// Register file with PC alias on the top index and same-cycle write-through
// of the writeback port onto both read ports.
module reg_file_bypass #(
    parameter  int WIDTH = 32,
    parameter  int NREGS = 16,
    localparam int RW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [RW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic [RW-1:0]    ra1,
    input  logic [RW-1:0]    ra2,
    input  logic [WIDTH-1:0] pc_plus8,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2
);

    localparam logic [RW-1:0] PC_IDX = RW'(NREGS - 1);

    logic [WIDTH-1:0] regs_r [NREGS];

    // Storage: the PC alias entry is never written, it only mirrors PC+8 on reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= '0;
            end
        end else if (we && (wa != PC_IDX)) begin
            regs_r[wa] <= wd;
        end
    end

    // Read port 1: PC alias beats the write-through bypass
    always_comb begin
        if (ra1 == PC_IDX) begin
            rd1 = pc_plus8;
        end else if (we && (ra1 == wa)) begin
            rd1 = wd;
        end else begin
            rd1 = regs_r[ra1];
        end
    end

    // Read port 2: same priority as port 1
    always_comb begin
        if (ra2 == PC_IDX) begin
            rd2 = pc_plus8;
        end else if (we && (ra2 == wa)) begin
            rd2 = wd;
        end else begin
            rd2 = regs_r[ra2];
        end
    end

endmodule

// File: rtl/decode_pipe.sv
// Decode stage with register file, immediate extension, load-use interlock
// and the Decode/Execute pipeline register.
module decode_pipe
    import pipeline_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int NREGS = 16,
    localparam int RW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      InstD,
    input  logic [WIDTH-1:0] PCPlus8D,
    input  logic             RegWriteW,
    input  logic [RW-1:0]    WA3W,
    input  logic [WIDTH-1:0] ResultW,
    input  logic [3:0]       InFlags,
    input  logic             FlushE,
    input  logic             StallE,
    output logic [WIDTH-1:0] RD1E,
    output logic [WIDTH-1:0] RD2E,
    output logic [WIDTH-1:0] ExtImmE,
    output logic [RW-1:0]    WA3E,
    output logic [RW-1:0]    RA1E,
    output logic [RW-1:0]    RA2E,
    output logic [RW-1:0]    RA1D,
    output logic [RW-1:0]    RA2D,
    output logic             PCSrcE,
    output logic             RegWriteE,
    output logic             MemtoRegE,
    output logic             MemWriteE,
    output logic             BranchE,
    output logic             ALUSrcE,
    output logic             ValidE,
    output logic [1:0]       ALUControlE,
    output logic [1:0]       FlagWriteE,
    output logic [3:0]       CondE,
    output logic [3:0]       FlagsE,
    output logic             StallD
);

    localparam logic [RW-1:0] PC_IDX = RW'(NREGS - 1);

    op_t              op_s;
    logic [5:0]       funct_s;
    logic [3:0]       cmd_s;
    logic [RW-1:0]    wa3_s;
    logic [1:0]       reg_src_s;
    imm_src_t         imm_src_s;
    de_ctrl_t         ctrl_s;
    logic [WIDTH-1:0] ext_imm_s;
    logic [WIDTH-1:0] rd1_s;
    logic [WIDTH-1:0] rd2_s;
    logic             ra2_used_s;

    de_ctrl_t         ctrl_r;
    logic             valid_r;
    logic [3:0]       cond_r;
    logic [3:0]       flags_r;
    logic [WIDTH-1:0] rd1_r;
    logic [WIDTH-1:0] rd2_r;
    logic [WIDTH-1:0] imm_r;
    logic [RW-1:0]    wa3_r;
    logic [RW-1:0]    ra1_r;
    logic [RW-1:0]    ra2_r;

    assign op_s    = op_t'(InstD[27:26]);
    assign funct_s = InstD[25:20];
    assign cmd_s   = funct_s[4:1];
    assign wa3_s   = RW'(InstD[15:12]);

    // Main control decode; Op 11 falls through as a NOP with every enable low
    always_comb begin
        ctrl_s    = CTRL_NOP;
        reg_src_s = 2'b00;
        imm_src_s = IMM_NONE;
        case (op_s)
            OP_DP: begin
                ctrl_s.reg_write = 1'b1;
                ctrl_s.alu_src   = funct_s[5];
                imm_src_s        = IMM_ZX8;
                case (cmd_s)
                    CMD_ADD: ctrl_s.alu_control = ALU_ADD;
                    CMD_SUB: ctrl_s.alu_control = ALU_SUB;
                    CMD_AND: ctrl_s.alu_control = ALU_AND;
                    CMD_ORR: ctrl_s.alu_control = ALU_ORR;
                    default: ctrl_s.alu_control = ALU_ADD;
                endcase
                ctrl_s.flag_write = {funct_s[0],
                                     funct_s[0] & ((cmd_s == CMD_ADD) | (cmd_s == CMD_SUB))};
            end
            OP_MEM: begin
                ctrl_s.alu_src = 1'b1;
                imm_src_s      = IMM_ZX12;
                if (funct_s[0]) begin
                    ctrl_s.reg_write  = 1'b1;
                    ctrl_s.mem_to_reg = 1'b1;
                end else begin
                    ctrl_s.mem_write = 1'b1;
                    reg_src_s        = 2'b10;
                end
            end
            OP_BR: begin
                ctrl_s.branch  = 1'b1;
                ctrl_s.alu_src = 1'b1;
                imm_src_s      = IMM_BR24;
                reg_src_s      = 2'b01;
            end
            default: begin
                ctrl_s = CTRL_NOP;
            end
        endcase
        ctrl_s.pc_src = ctrl_s.branch | (ctrl_s.reg_write & (wa3_s == PC_IDX));
    end

    // Immediate extension; branch offsets are word-scaled and sign-extended
    always_comb begin
        case (imm_src_s)
            IMM_ZX8:  ext_imm_s = WIDTH'(InstD[7:0]);
            IMM_ZX12: ext_imm_s = WIDTH'(InstD[11:0]);
            IMM_BR24: ext_imm_s = {{(WIDTH - 26){InstD[23]}}, InstD[23:0], 2'b00};
            default:  ext_imm_s = '0;
        endcase
    end

    assign RA1D       = reg_src_s[0] ? PC_IDX : RW'(InstD[19:16]);
    assign RA2D       = reg_src_s[1] ? RW'(InstD[15:12]) : RW'(InstD[3:0]);
    assign ra2_used_s = (op_s != OP_BR);

    assign StallD = ValidE & MemtoRegE
                  & ((WA3E == RA1D) | ((WA3E == RA2D) & ra2_used_s))
                  & ~FlushE;

    reg_file_bypass #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_rf (
        .clk      (clk),
        .reset    (reset),
        .we       (RegWriteW),
        .wa       (WA3W),
        .wd       (ResultW),
        .ra1      (RA1D),
        .ra2      (RA2D),
        .pc_plus8 (PCPlus8D),
        .rd1      (rd1_s),
        .rd2      (rd2_s)
    );

    // Decode/Execute register: flush, then hold, then load-use bubble, then load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r <= 1'b0;
            ctrl_r  <= CTRL_NOP;
            cond_r  <= 4'd0;
            flags_r <= 4'd0;
            rd1_r   <= '0;
            rd2_r   <= '0;
            imm_r   <= '0;
            wa3_r   <= '0;
            ra1_r   <= '0;
            ra2_r   <= '0;
        end else if (FlushE || (!StallE && StallD)) begin
            valid_r <= 1'b0;
            ctrl_r  <= CTRL_NOP;
            cond_r  <= 4'd0;
            flags_r <= 4'd0;
        end else if (!StallE) begin
            valid_r <= 1'b1;
            ctrl_r  <= ctrl_s;
            cond_r  <= InstD[31:28];
            flags_r <= InFlags;
            rd1_r   <= rd1_s;
            rd2_r   <= rd2_s;
            imm_r   <= ext_imm_s;
            wa3_r   <= wa3_s;
            ra1_r   <= RA1D;
            ra2_r   <= RA2D;
        end
    end

    assign ValidE      = valid_r;
    assign PCSrcE      = ctrl_r.pc_src;
    assign RegWriteE   = ctrl_r.reg_write;
    assign MemtoRegE   = ctrl_r.mem_to_reg;
    assign MemWriteE   = ctrl_r.mem_write;
    assign BranchE     = ctrl_r.branch;
    assign ALUSrcE     = ctrl_r.alu_src;
    assign ALUControlE = ctrl_r.alu_control;
    assign FlagWriteE  = ctrl_r.flag_write;
    assign CondE       = cond_r;
    assign FlagsE      = flags_r;
    assign RD1E        = rd1_r;
    assign RD2E        = rd2_r;
    assign ExtImmE     = imm_r;
    assign WA3E        = wa3_r;
    assign RA1E        = ra1_r;
    assign RA2E        = ra2_r;

endmodule

// File: tb/tb_decode_pipe.sv
// Randomized bench for decode_pipe against an instruction-level reference model,
// plus directed scenarios on a default and a 64-bit/32-register instance.
module tb_decode_pipe;

    typedef struct packed {
        logic        valid;
        logic [9:0]  ctrl;   // {pcs, rw, m2r, mw, br, asrc, aluc[1:0], fw[1:0]}
        logic [3:0]  cond;
        logic [3:0]  flags;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [3:0]  wa3;
        logic [3:0]  ra1;
        logic [3:0]  ra2;
    } e_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] inst_d, pc8_d, result_w;
    logic        reg_write_w, flush_e, stall_e;
    logic [3:0]  wa3_w, in_flags;

    logic [31:0] rd1_e, rd2_e, ext_imm_e;
    logic [3:0]  wa3_e, ra1_e, ra2_e, ra1_d, ra2_d, cond_e, flags_e;
    logic        pc_src_e, reg_write_e, mem_to_reg_e, mem_write_e, branch_e, alu_src_e, valid_e, stall_d;
    logic [1:0]  alu_control_e, flag_write_e;

    logic [63:0] pc8_64, result_64;
    logic [4:0]  wa3_64;
    logic [63:0] rd1_64, rd2_64, imm_64;
    logic [4:0]  wa3e_64, ra1e_64, ra2e_64, ra1d_64, ra2d_64;
    logic        pcs_64, rw_64, m2r_64, mw_64, br_64, asrc_64, valid_64, stall_64;
    logic [1:0]  aluc_64, fw_64;
    logic [3:0]  cond_64, flags_64;

    assign pc8_64    = {32'hDEAD_BEEF, pc8_d};
    assign result_64 = {32'hCAFE_0000, result_w};
    assign wa3_64    = {1'b0, wa3_w};

    decode_pipe dut (
        .clk(clk), .reset(reset), .InstD(inst_d), .PCPlus8D(pc8_d),
        .RegWriteW(reg_write_w), .WA3W(wa3_w), .ResultW(result_w), .InFlags(in_flags),
        .FlushE(flush_e), .StallE(stall_e),
        .RD1E(rd1_e), .RD2E(rd2_e), .ExtImmE(ext_imm_e), .WA3E(wa3_e), .RA1E(ra1_e), .RA2E(ra2_e),
        .RA1D(ra1_d), .RA2D(ra2_d), .PCSrcE(pc_src_e), .RegWriteE(reg_write_e),
        .MemtoRegE(mem_to_reg_e), .MemWriteE(mem_write_e), .BranchE(branch_e), .ALUSrcE(alu_src_e),
        .ValidE(valid_e), .ALUControlE(alu_control_e), .FlagWriteE(flag_write_e),
        .CondE(cond_e), .FlagsE(flags_e), .StallD(stall_d)
    );

    decode_pipe #(.WIDTH(64), .NREGS(32)) dut64 (
        .clk(clk), .reset(reset), .InstD(inst_d), .PCPlus8D(pc8_64),
        .RegWriteW(reg_write_w), .WA3W(wa3_64), .ResultW(result_64), .InFlags(in_flags),
        .FlushE(flush_e), .StallE(stall_e),
        .RD1E(rd1_64), .RD2E(rd2_64), .ExtImmE(imm_64), .WA3E(wa3e_64), .RA1E(ra1e_64), .RA2E(ra2e_64),
        .RA1D(ra1d_64), .RA2D(ra2d_64), .PCSrcE(pcs_64), .RegWriteE(rw_64),
        .MemtoRegE(m2r_64), .MemWriteE(mw_64), .BranchE(br_64), .ALUSrcE(asrc_64),
        .ValidE(valid_64), .ALUControlE(aluc_64), .FlagWriteE(fw_64),
        .CondE(cond_64), .FlagsE(flags_64), .StallD(stall_64)
    );

    int          n_cmp;
    int          n_bad;
    logic [31:0] mdl_regs [16];
    e_t          e_m;
    logic        last_stall;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mdl_read(input logic [3:0] a, input logic [31:0] pc8,
                                             input logic we, input logic [3:0] wa, input logic [31:0] wd);
        if (a == 4'd15) return pc8;
        if (we && wa == a) return wd;
        return mdl_regs[a];
    endfunction

    // Instruction-level meaning of one Decode-stage instruction
    function automatic e_t mdl_decode(input logic [31:0] inst, input logic [31:0] pc8, input logic [3:0] flg,
                                      input logic we, input logic [3:0] wa, input logic [31:0] wd);
        e_t          e;
        logic        pcs, rw, m2r, mw, br, asrc;
        logic [1:0]  aluc, fw;
        logic [3:0]  cmd;
        int          off;
        e = '0;
        pcs = 1'b0; rw = 1'b0; m2r = 1'b0; mw = 1'b0; br = 1'b0; asrc = 1'b0;
        aluc = 2'd0; fw = 2'd0;
        cmd   = inst[24:21];
        e.ra1 = inst[19:16];
        e.ra2 = inst[3:0];
        e.wa3 = inst[15:12];
        case (inst[27:26])
            2'b00: begin
                rw = 1'b1; asrc = inst[25]; e.imm = {24'd0, inst[7:0]};
                if (cmd == 4'b0100) aluc = 2'd0;
                else if (cmd == 4'b0010) aluc = 2'd1;
                else if (cmd == 4'b0000) aluc = 2'd2;
                else if (cmd == 4'b1100) aluc = 2'd3;
                else aluc = 2'd0;
                fw = {inst[20], inst[20] && (cmd == 4'b0100 || cmd == 4'b0010)};
            end
            2'b01: begin
                asrc = 1'b1; e.imm = {20'd0, inst[11:0]};
                if (inst[20]) begin rw = 1'b1; m2r = 1'b1; end
                else begin mw = 1'b1; e.ra2 = inst[15:12]; end
            end
            2'b10: begin
                br = 1'b1; asrc = 1'b1; e.ra1 = 4'd15;
                off = $signed(inst[23:0]);
                e.imm = 32'(off * 4);
            end
            default: e.imm = 32'd0;
        endcase
        pcs    = br || (rw && inst[15:12] == 4'd15);
        e.ctrl = {pcs, rw, m2r, mw, br, asrc, aluc, fw};
        e.valid = 1'b1;
        e.cond  = inst[31:28];
        e.flags = flg;
        e.rd1   = mdl_read(e.ra1, pc8, we, wa, wd);
        e.rd2   = mdl_read(e.ra2, pc8, we, wa, wd);
        return e;
    endfunction

    function automatic logic [3:0] small_reg();
        return ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] v;
        int          r;
        v = $urandom;
        r = $urandom_range(0, 9);
        v[27:26] = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
        v[19:16] = small_reg();
        v[15:12] = small_reg();
        v[3:0]   = small_reg();
        return v;
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < 16; i++) mdl_regs[i] = 32'd0;
        e_m = '0;
        last_stall = 1'b0;
    endtask

    task automatic drive(input logic [31:0] inst, input logic [31:0] pc8, input logic we,
                         input logic [3:0] wa, input logic [31:0] wd, input logic fl, input logic st);
        inst_d = inst; pc8_d = pc8; reg_write_w = we; wa3_w = wa; result_w = wd;
        flush_e = fl; stall_e = st; in_flags = 4'($urandom_range(0, 15));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ctl32"}, {valid_e, pc_src_e, reg_write_e, mem_to_reg_e, mem_write_e, branch_e,
                              alu_src_e, alu_control_e, flag_write_e, cond_e, flags_e, stall_d}, 64'd0);
        chk({tag, "_rd32"}, {rd1_e, rd2_e}, 64'd0);
        chk({tag, "_imm32"}, {20'd0, wa3_e, ra1_e, ra2_e, ext_imm_e}, 64'd0);
        chk({tag, "_ctl64"}, {valid_64, pcs_64, rw_64, m2r_64, mw_64, br_64, asrc_64, aluc_64, fw_64,
                              cond_64, flags_64, stall_64, wa3e_64, ra1e_64, ra2e_64}, 64'd0);
        chk({tag, "_rd1_64"}, rd1_64, 64'd0);
        chk({tag, "_rd2_64"}, rd2_64, 64'd0);
        chk({tag, "_imm64"}, imm_64, 64'd0);
    endtask

    // One clock: check Decode-side outputs, advance the model, check Execute outputs
    task automatic step();
        e_t   dec, nxt;
        logic stall_x;
        #1;
        dec = mdl_decode(inst_d, pc8_d, in_flags, reg_write_w, wa3_w, result_w);
        stall_x = e_m.valid && e_m.ctrl[7] && !flush_e &&
                  (e_m.wa3 == dec.ra1 || (e_m.wa3 == dec.ra2 && inst_d[27:26] != 2'b10));
        chk("ra1d", {60'd0, ra1_d}, {60'd0, dec.ra1});
        chk("ra2d", {60'd0, ra2_d}, {60'd0, dec.ra2});
        chk("stalld", {63'd0, stall_d}, {63'd0, stall_x});
        last_stall = stall_x;
        if (flush_e || (!stall_e && stall_x)) begin
            nxt = e_m; nxt.valid = 1'b0; nxt.ctrl = 10'd0;
        end else if (stall_e) begin
            nxt = e_m;
        end else begin
            nxt = dec;
        end
        @(posedge clk);
        if (reg_write_w && wa3_w != 4'd15) mdl_regs[wa3_w] = result_w;
        e_m = nxt;
        #1;
        chk("valide", {63'd0, valid_e}, {63'd0, e_m.valid});
        chk("ctrle", {54'd0, pc_src_e, reg_write_e, mem_to_reg_e, mem_write_e, branch_e, alu_src_e,
                      alu_control_e, flag_write_e}, {54'd0, e_m.ctrl});
        if (e_m.valid) begin
            chk("condflags", {56'd0, cond_e, flags_e}, {56'd0, e_m.cond, e_m.flags});
            chk("rd1e", {32'd0, rd1_e}, {32'd0, e_m.rd1});
            chk("rd2e", {32'd0, rd2_e}, {32'd0, e_m.rd2});
            chk("extimme", {32'd0, ext_imm_e}, {32'd0, e_m.imm});
            chk("regidx", {52'd0, wa3_e, ra1_e, ra2_e}, {52'd0, e_m.wa3, e_m.ra1, e_m.ra2});
        end
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        mdl_reset();
        drive(32'hF000_0000, 32'd8, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk_reset("por");
        reset = 1'b0;

        // Write R3 then read it through an ADD
        drive(32'hF000_0000, 32'h100, 1'b1, 4'd3, 32'h0000_00AA, 1'b0, 1'b0);
        step();
        drive(32'hE083_1004, 32'h104, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
        step();
        chk("wr_rd_r3", {31'd0, valid_e, rd1_e}, {31'd0, 1'b1, 32'h0000_00AA});
        chk("wr_rd_r3_64", rd1_64, 64'hCAFE_0000_0000_00AA);

        // Same-cycle write-through of R5
        drive(32'hE085_1004, 32'h108, 1'b1, 4'd5, 32'h0000_1234, 1'b0, 1'b0);
        step();
        chk("bypass_r5", {32'd0, rd1_e}, 64'h0000_1234);

        // Load-use: LDR R2 in Execute, ADD reading R2 in Decode
        drive(32'hE591_2000, 32'h10C, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
        step();
        drive(32'hE082_3004, 32'h110, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
        #1;
        chk("lu_stalld", {63'd0, stall_d}, 64'd1);
        step();
        chk("lu_bubble", {62'd0, valid_e, reg_write_e}, 64'd0);
        step();
        chk("lu_issue", {59'd0, valid_e, ra1_e}, {59'd0, 1'b1, 4'd2});

        // Branch back: sign-extended offset and PC alias read
        drive(32'hEAFF_FFFE, 32'h108, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
        #1;
        chk("pc_alias64_ra1d", {59'd0, ra1d_64}, 64'd31);
        step();
        chk("br_imm", {32'd0, ext_imm_e}, 64'hFFFF_FFF8);
        chk("br_pc", {32'd0, rd1_e}, 64'h108);
        chk("br_imm64", imm_64, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("br_pc64", rd1_64, 64'hDEAD_BEEF_0000_0108);

        // Flush and stall together: flush wins
        drive(32'hE591_2000, 32'h10C, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
        step();
        drive(32'hE082_3004, 32'h110, 1'b0, 4'd0, 32'd0, 1'b1, 1'b1);
        step();
        chk("flush_stall", {61'd0, valid_e, reg_write_e, mem_write_e}, 64'd0);

        // Randomized traffic; Fetch holds InstD while Decode is stalled
        for (int c = 0; c < 600; c++) begin
            logic [31:0] keep;
            keep = inst_d;
            drive(rand_inst(), $urandom, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3)),
                  $urandom, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
            if (last_stall) inst_d = keep;
            step();
        end

        // Asynchronous reset between edges, with a valid instruction in Execute
        drive(32'hE083_1004, 32'h200, 1'b1, 4'd3, 32'h0000_0055, 1'b0, 1'b0);
        step();
        drive(32'hE083_1004, 32'h204, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk_reset("mid");
        mdl_reset();
        reset = 1'b0;
        step();
        chk("post_rst_r3", {31'd0, valid_e, rd1_e}, {31'd0, 1'b1, 32'd0});
        chk("post_rst_r3_64", rd1_64, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
